fx3_dpo_sched: RTL

- Round-robin scheduler that shares the FX3 upstream (FPGA->host) write path between the output data-port FIFOs (DP1, DP2, DP3).
- Grants one port per burst, pops words from it into the FX3 write engine, and drives that port's slave-FIFO endpoint address.
- Ends each burst with either a full packet or a PKTEND-terminated short packet.
- Sits between the dual-clock output FIFOs (read side, clk_i domain) and fx3_ctrl's write datapath.

---
 rtl/fx3_dpo_sched.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fx3_dpo_sched.sv
// fx3_dpo_sched: round-robin scheduler that shares the FX3 upstream write path
// between the output data-port FIFOs. One port is granted per burst. Words are
// popped from that port into the write engine, and the burst closes with either
// a full packet or a PKTEND-terminated short packet.
// Optional per-port burst statistics are compiled in with FX3_SCHED_STATS_EN.
module fx3_dpo_sched #(
    parameter int         NumPorts    = 3,
    parameter int         GpifWidth   = 32,
    parameter int         BurstLen    = 256,
    parameter int         IdleTimeout = 64,
    parameter logic [7:0] EpAddrMap   = 8'b11_10_01_00
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           port_en_i,
    input  logic [NumPorts-1:0]           port_epty_i,
    input  logic [NumPorts*GpifWidth-1:0] port_dt_i,
    output logic [NumPorts-1:0]           port_rd_o,
    input  logic                          wr_rdy_i,
    output logic [GpifWidth-1:0]          dt_o,
    output logic                          dt_vld_o,
    output logic [1:0]                    sladdr_o,
    output logic                          pktend_o,
    output logic [NumPorts-1:0]           gnt_o,
    output logic                          busy_o
`ifdef FX3_SCHED_STATS_EN
    ,
    input  logic                          stats_clr_i,
    output logic [NumPorts*16-1:0]        stats_full_o,
    output logic [NumPorts*16-1:0]        stats_short_o
`endif
);

    localparam int CW = $clog2(BurstLen) + 1;
    localparam int TW = $clog2(IdleTimeout) + 1;
    localparam logic [CW-1:0] BURST_LEN  = CW'(BurstLen);
    localparam logic [CW-1:0] BURST_LAST = CW'(BurstLen - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(IdleTimeout - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_XFER   = 3'd2,
        S_DRAIN  = 3'd3,
        S_PKTEND = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]          r_ptr;
    logic [1:0]          r_gidx;
    logic [NumPorts-1:0] r_gnt;
    logic [1:0]          r_sladdr;
    logic [CW-1:0]       r_wcnt;
    logic [TW-1:0]       r_tcnt;
    logic                r_full;
    logic                r_dt_vld;

    // Per-port views padded to four entries so a 2-bit index is always exact.
    logic [3:0]           w_en_pad;
    logic [3:0]           w_epty_pad;
    logic [3:0]           w_elig_pad;
    logic [GpifWidth-1:0] w_dt_arr [4];

    logic       w_arb_found;
    logic [1:0] w_arb_idx;
    logic [2:0] w_sum;
    logic [1:0] w_arb_sladdr;
    logic [3:0] w_arb_gnt_pad;
    logic [1:0] w_ptr_next;
    logic       w_g_en;
    logic       w_g_epty;
    logic       w_rd;
    logic       w_last_rd;
    logic       w_timeout;
    logic [3:0] w_rd_pad;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < NumPorts) begin : g_on
                assign w_en_pad[gi]   = port_en_i[gi];
                assign w_epty_pad[gi] = port_epty_i[gi];
                assign w_dt_arr[gi]   = port_dt_i[gi*GpifWidth +: GpifWidth];
            end else begin : g_off
                assign w_en_pad[gi]   = 1'b0;
                assign w_epty_pad[gi] = 1'b1;
                assign w_dt_arr[gi]   = '0;
            end
        end
    endgenerate

    assign w_elig_pad = w_en_pad & ~w_epty_pad;

    // Round-robin pick: scan offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = 2'd0;
        w_sum       = 3'd0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + 3'(k);
            if (w_sum >= 3'(NumPorts)) begin
                w_sum = w_sum - 3'(NumPorts);
            end
            if (w_elig_pad[w_sum[1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_sum[1:0];
            end
        end
    end

    assign w_arb_sladdr  = EpAddrMap[{w_arb_idx, 1'b0} +: 2];
    assign w_arb_gnt_pad = 4'b0001 << w_arb_idx;
    assign w_ptr_next    = (r_gidx == 2'(NumPorts - 1)) ? 2'd0 : r_gidx + 2'd1;

    // Read qualification for the granted port; a read during reset would lose a word.
    always_comb begin
        w_g_en    = w_en_pad[r_gidx];
        w_g_epty  = w_epty_pad[r_gidx];
        w_rd      = (r_state == S_XFER) & ~rst_i & wr_rdy_i & ~w_g_epty & w_g_en
                    & (r_wcnt < BURST_LEN);
        w_last_rd = w_rd & (r_wcnt == BURST_LAST);
        w_timeout = ~w_rd & (w_g_epty | ~w_g_en) & (r_tcnt >= TO_LAST);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a read always takes priority over timeout expiry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (|w_elig_pad) w_state_next = S_ARB;
            S_ARB:    w_state_next = w_arb_found ? S_XFER : S_IDLE;
            S_XFER: begin
                if (w_last_rd || !w_g_en || w_timeout) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN:  w_state_next = r_full ? S_IDLE : S_PKTEND;
            S_PKTEND: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output decode: strobes from state, data muxed from the granted FIFO one cycle after its read.
    always_comb begin
        w_rd_pad  = w_rd ? (4'b0001 << r_gidx) : 4'b0000;
        port_rd_o = w_rd_pad[NumPorts-1:0];
        pktend_o  = (r_state == S_PKTEND);
        busy_o    = (r_state != S_IDLE);
        dt_vld_o  = r_dt_vld;
        dt_o      = r_dt_vld ? w_dt_arr[r_gidx] : '0;
        gnt_o     = r_gnt;
        sladdr_o  = r_sladdr;
    end

    // Grant, pointer, counters and read-valid pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr    <= 2'd0;
            r_gidx   <= 2'd0;
            r_gnt    <= '0;
            r_sladdr <= 2'd0;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_full   <= 1'b0;
            r_dt_vld <= 1'b0;
        end else begin
            r_dt_vld <= w_rd;
            case (r_state)
                S_ARB: begin
                    if (w_arb_found) begin
                        r_gidx   <= w_arb_idx;
                        r_gnt    <= w_arb_gnt_pad[NumPorts-1:0];
                        r_sladdr <= w_arb_sladdr;
                        r_wcnt   <= '0;
                        r_tcnt   <= '0;
                        r_full   <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (w_rd) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        r_tcnt <= '0;
                    end else if (r_tcnt < TO_LAST) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                    if (w_last_rd) begin
                        r_full <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_full) begin
                        r_gnt <= '0;
                        r_ptr <= w_ptr_next;
                    end
                end
                S_PKTEND: begin
                    r_gnt <= '0;
                    r_ptr <= w_ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FX3_SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_stats
            logic [15:0] r_full_cnt;
            logic [15:0] r_short_cnt;

            // Saturating per-port burst counters.
            always_ff @(posedge clk_i) begin
                if (rst_i || stats_clr_i) begin
                    r_full_cnt  <= 16'd0;
                    r_short_cnt <= 16'd0;
                end else begin
                    if (r_state == S_DRAIN && r_full && r_gidx == 2'(gi)
                        && r_full_cnt != 16'hFFFF) begin
                        r_full_cnt <= r_full_cnt + 16'd1;
                    end
                    if (r_state == S_PKTEND && r_gidx == 2'(gi)
                        && r_short_cnt != 16'hFFFF) begin
                        r_short_cnt <= r_short_cnt + 16'd1;
                    end
                end
            end

            assign stats_full_o[gi*16 +: 16]  = r_full_cnt;
            assign stats_short_o[gi*16 +: 16] = r_short_cnt;
        end
    endgenerate
`endif

endmodule
